// File: rtl/map_pkg.sv
// Shared definitions for the battlefield tile-map write-side controller:
// tile codes, map geometry and the queued hit request record.
package map_pkg;

    localparam logic [2:0] TILE_EMPTY     = 3'd0;
    localparam logic [2:0] TILE_BRICK     = 3'd1;
    localparam logic [2:0] TILE_STEEL     = 3'd2;
    localparam logic [2:0] TILE_WATER     = 3'd3;
    localparam logic [2:0] TILE_TREE      = 3'd4;
    localparam logic [2:0] TILE_ICE       = 3'd5;
    localparam logic [2:0] TILE_BASE      = 3'd6;
    localparam logic [2:0] TILE_BASE_DEAD = 3'd7;

    localparam int unsigned MAP_COLS  = 16;
    localparam int unsigned MAP_ROWS  = 12;
    localparam int unsigned MAP_TILES = 192;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       power;
    } hit_req_t;

    // Row-major tile index: y*16 + x.
    function automatic logic [7:0] tile_index(input logic [3:0] x, input logic [3:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/map_hit_fifo.sv
// Synchronous FIFO holding pending hit requests; flush empties it in one cycle.
// FIFO_DEPTH must be a power of two, at least 2.
module map_hit_fifo
    import map_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush_i,
    input  logic     push_i,
    input  hit_req_t wdata_i,
    input  logic     pop_i,
    output hit_req_t rdata_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    hit_req_t    mem_q [FIFO_DEPTH];
    logic        do_push, do_pop;

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/map_update.sv
// Tile-map write-side controller: level bulk load and bullet-hit read-modify-write.
// Define MAP_UPDATE_STEEL_BREAK_EN to let powered bullets destroy steel.
module map_update
    import map_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 3,
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hit_valid_i,
    output logic                  hit_ready_o,
    input  logic [3:0]            hit_x_i,
    input  logic [3:0]            hit_y_i,
    input  logic                  hit_power_i,
    input  logic                  load_start_i,
    output logic                  load_busy_o,
    output logic [7:0]            rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [ADDR_WIDTH-1:0] map_raddr_o,
    input  logic [DATA_WIDTH-1:0] map_rdata_i,
    output logic                  map_we_o,
    output logic [ADDR_WIDTH-1:0] map_waddr_o,
    output logic [DATA_WIDTH-1:0] map_wdata_o,
    output logic                  base_hit_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_LOOKUP = 2'd2;
    localparam logic [1:0] ST_WRITE  = 2'd3;

`ifdef MAP_UPDATE_STEEL_BREAK_EN
    localparam logic STEEL_BREAK = 1'b1;
`else
    localparam logic STEEL_BREAK = 1'b0;
`endif

    logic [1:0]            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    hit_req_t              req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  base_hit_q, base_hit_d;

    hit_req_t              fifo_wdata, fifo_head;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ADDR_WIDTH-1:0] lookup_addr;

    assign fifo_wdata.x     = hit_x_i;
    assign fifo_wdata.y     = hit_y_i;
    assign fifo_wdata.power = hit_power_i;

    assign load_busy_o = (state_q == ST_LOAD);
    // Gated by rst so every output reads 0 while reset is held.
    assign hit_ready_o = !rst && !fifo_full && !load_busy_o;
    // Off-map rows are accepted but never queued.
    assign fifo_push   = hit_valid_i && hit_ready_o && (hit_y_i < 4'(MAP_ROWS));

    assign lookup_addr = ADDR_WIDTH'(tile_index(req_q.x, req_q.y));
    assign map_raddr_o = lookup_addr;
    assign rom_addr_o  = cnt_q;
    assign map_we_o    = we_q;
    assign map_waddr_o = waddr_q;
    assign map_wdata_o = wdata_q;
    assign base_hit_o  = base_hit_q;

    map_hit_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (load_start_i),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        base_hit_d = 1'b0;
        fifo_pop   = 1'b0;

        // A new level load overrides everything, dropping any in-flight hit.
        if (load_start_i) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        req_d    = fifo_head;
                        state_d  = ST_LOOKUP;
                    end
                end
                ST_LOAD: begin
                    we_d    = 1'b1;
                    waddr_d = ADDR_WIDTH'(cnt_q);
                    wdata_d = rom_data_i;
                    if (cnt_q == 8'(MAP_TILES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_LOOKUP: begin
                    state_d = ST_WRITE;
                    if (map_rdata_i == DATA_WIDTH'(TILE_BRICK) ||
                        (map_rdata_i == DATA_WIDTH'(TILE_STEEL) && STEEL_BREAK && req_q.power)) begin
                        we_d    = 1'b1;
                        waddr_d = lookup_addr;
                        wdata_d = DATA_WIDTH'(TILE_EMPTY);
                    end else if (map_rdata_i == DATA_WIDTH'(TILE_BASE)) begin
                        we_d       = 1'b1;
                        waddr_d    = lookup_addr;
                        wdata_d    = DATA_WIDTH'(TILE_BASE_DEAD);
                        base_hit_d = 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        req_d    = fifo_head;
                        state_d  = ST_LOOKUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            base_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            base_hit_q <= base_hit_d;
        end
    end

endmodule

// File: tb/tb_map_update.sv
// Self-checking bench for map_update: models level ROM and map RAM, predicts
// writes from the tile rules and acceptance timing from a queue occupancy model.
module tb_map_update;

`ifdef MAP_UPDATE_STEEL_BREAK_EN
    localparam bit STEEL_EN = 1'b1;
`else
    localparam bit STEEL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        hit_valid, hit_ready, hit_power, load_start, load_busy;
    logic [3:0]  hit_x, hit_y;
    logic [7:0]  rom_addr;
    logic [2:0]  rom_data, map_rdata, map_wdata;
    logic [14:0] map_raddr, map_waddr;
    logic        map_we, base_hit;

    always #5 clk = ~clk;

    map_update u_dut (
        .clk          (clk),
        .rst          (rst),
        .hit_valid_i  (hit_valid),
        .hit_ready_o  (hit_ready),
        .hit_x_i      (hit_x),
        .hit_y_i      (hit_y),
        .hit_power_i  (hit_power),
        .load_start_i (load_start),
        .load_busy_o  (load_busy),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .map_raddr_o  (map_raddr),
        .map_rdata_i  (map_rdata),
        .map_we_o     (map_we),
        .map_waddr_o  (map_waddr),
        .map_wdata_o  (map_wdata),
        .base_hit_o   (base_hit)
    );

    // Environment: combinational ROM, RAM with async read and clocked write.
    logic [2:0] rom [256];
    logic [2:0] ram [192];
    assign rom_data  = rom[rom_addr];
    assign map_rdata = (map_raddr < 15'd192) ? ram[map_raddr[7:0]] : 3'd0;
    always @(posedge clk) if (map_we && map_waddr < 15'd192) ram[map_waddr[7:0]] <= map_wdata;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    int  cyc = 0;
    wr_t obs_q[$];
    int  base_q[$];
    wr_t mon_w;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!rst && map_we) begin
            mon_w.addr = int'(map_waddr);
            mon_w.data = int'(map_wdata);
            mon_w.cyc  = cyc;
            obs_q.push_back(mon_w);
        end
        if (!rst && base_hit) base_q.push_back(cyc);
    end

    int  n_cmp = 0;
    int  n_bad = 0;
    int  mdl[192];
    wr_t exp_q[$];
    int  exp_base = 0;

    // Reference rules applied in acceptance order.
    task automatic model_hit(input int x, input int y, input int p);
        int  a;
        wr_t e;
        if (y >= 12) return;
        a = y * 16 + x;
        e.addr = a;
        e.cyc  = 0;
        if (mdl[a] == 1 || (mdl[a] == 2 && STEEL_EN && p != 0)) begin
            e.data = 0;
            exp_q.push_back(e);
            mdl[a] = 0;
        end else if (mdl[a] == 6) begin
            e.data = 7;
            exp_q.push_back(e);
            mdl[a] = 7;
            exp_base++;
        end
    endtask

    task automatic clear_logs();
        obs_q.delete();
        base_q.delete();
        exp_q.delete();
        exp_base = 0;
    endtask

    task automatic send_hit(input int x, input int y, input int p, output int acc);
        int w = 0;
        @(negedge clk);
        hit_valid = 1'b1;
        hit_x     = 4'(x);
        hit_y     = 4'(y);
        hit_power = 1'(p);
        while (!hit_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!hit_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL hit_accept_timeout: hit_ready=%0b want 1", hit_ready);
            hit_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        model_hit(x, y, p);
    endtask

    task automatic end_hit();
        @(negedge clk);
        hit_valid = 1'b0;
    endtask

    task automatic do_load(output int edge_cyc, output int busy_n);
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        edge_cyc = cyc;
        @(negedge clk);
        load_start = 1'b0;
        busy_n = 0;
        while (load_busy && busy_n < 400) begin
            busy_n++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hit_valid = 1'b0; hit_x = '0; hit_y = '0; hit_power = 1'b0; load_start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({map_we, base_hit, load_busy, hit_ready, rom_addr, map_waddr, map_wdata, map_raddr}
            !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: we=%b bh=%b busy=%b rdy=%b rom=%0d wa=%0d wd=%0d ra=%0d want all 0",
                     map_we, base_hit, load_busy, hit_ready, rom_addr, map_waddr, map_wdata, map_raddr);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (hit_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: got %b want 1", hit_ready);
        end
    endtask

    task automatic test_load_mod8();
        int e, busy;
        for (int i = 0; i < 256; i++) rom[i] = 3'(i % 8);
        clear_logs();
        do_load(e, busy);
        n_cmp++;
        if (busy != 192) begin
            n_bad++;
            $display("FAIL load_busy_cycles: got %0d want 192", busy);
        end
        n_cmp++;
        if (obs_q.size() != 192) begin
            n_bad++;
            $display("FAIL load_write_count: got %0d want 192", obs_q.size());
        end else begin
            for (int i = 0; i < 192; i++) begin
                n_cmp++;
                if (obs_q[i].addr != i || obs_q[i].data != i % 8 || obs_q[i].cyc != e + 1 + i) begin
                    n_bad++;
                    $display("FAIL load_write[%0d]: addr=%0d data=%0d cyc=%0d want %0d %0d %0d",
                             i, obs_q[i].addr, obs_q[i].data, obs_q[i].cyc, i, i % 8, e + 1 + i);
                end
            end
        end
    endtask

    task automatic load_game_map();
        int e, busy;
        for (int i = 0; i < 256; i++) rom[i] = 3'($urandom_range(0, 6));
        rom[35] = 3'd1; rom[191] = 3'd6; rom[0] = 3'd1;
        rom[5*16+7] = 3'd2; rom[6*16+7] = 3'd2; rom[4*16+9] = 3'd3;
        clear_logs();
        do_load(e, busy);
        for (int i = 0; i < 192; i++) mdl[i] = int'(rom[i]);
        n_cmp++;
        if (obs_q.size() != 192) begin
            n_bad++;
            $display("FAIL game_load_count: got %0d want 192", obs_q.size());
        end
    endtask

    task automatic test_brick();
        int acc;
        clear_logs();
        send_hit(3, 2, 0, acc);
        end_hit();
        repeat (6) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 1 || base_q.size() != 0) begin
            n_bad++;
            $display("FAIL brick_count: writes=%0d pulses=%0d want 1 0", obs_q.size(), base_q.size());
        end else begin
            n_cmp++;
            if (obs_q[0].addr != 35 || obs_q[0].data != 0 || obs_q[0].cyc != acc + 2) begin
                n_bad++;
                $display("FAIL brick_write: addr=%0d data=%0d cyc=%0d want 35 0 %0d",
                         obs_q[0].addr, obs_q[0].data, obs_q[0].cyc, acc + 2);
            end
        end
    endtask

    task automatic test_base();
        int acc;
        clear_logs();
        send_hit(15, 11, 0, acc);
        end_hit();
        repeat (6) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 1 || base_q.size() != 1) begin
            n_bad++;
            $display("FAIL base_count: writes=%0d pulses=%0d want 1 1", obs_q.size(), base_q.size());
        end else begin
            n_cmp++;
            if (obs_q[0].addr != 191 || obs_q[0].data != 7 || base_q[0] != acc + 2) begin
                n_bad++;
                $display("FAIL base_write: addr=%0d data=%0d pulse_cyc=%0d want 191 7 %0d",
                         obs_q[0].addr, obs_q[0].data, base_q[0], acc + 2);
            end
        end
        clear_logs();
        send_hit(15, 11, 0, acc);
        end_hit();
        repeat (6) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0 || base_q.size() != 0) begin
            n_bad++;
            $display("FAIL base_again: writes=%0d pulses=%0d want 0 0", obs_q.size(), base_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        clear_logs();
        send_hit(0, 0, 0, acc);
        send_hit(0, 0, 1, acc);
        end_hit();
        repeat (8) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_bad++;
            $display("FAIL b2b_same_tile: writes=%0d want 1", obs_q.size());
        end else begin
            n_cmp++;
            if (obs_q[0].addr != 0 || obs_q[0].data != 0) begin
                n_bad++;
                $display("FAIL b2b_write: addr=%0d data=%0d want 0 0", obs_q[0].addr, obs_q[0].data);
            end
        end
    endtask

    // Continuous random stream: predicts acceptance edges from queue occupancy.
    task automatic test_stream();
        localparam int N = 10;
        int acc[N];
        int pa[N];
        int ps[N];
        int t, occ;
        clear_logs();
        for (int i = 0; i < N; i++) begin
            send_hit($urandom_range(0, 15), $urandom_range(0, 11), $urandom_range(0, 1), acc[i]);
        end
        end_hit();
        repeat (30) @(negedge clk);
        pa[0] = acc[0];
        ps[0] = acc[0] + 1;
        for (int i = 1; i < N; i++) begin
            t = pa[i-1] + 1;
            for (int k = 0; k < 100; k++) begin
                occ = 0;
                for (int j = 0; j < i; j++) begin
                    if (pa[j] < t) occ++;
                    if (ps[j] < t) occ--;
                end
                if (occ < 4) break;
                t++;
            end
            pa[i] = t;
            ps[i] = (t + 1 > ps[i-1] + 2) ? t + 1 : ps[i-1] + 2;
        end
        for (int i = 1; i < N; i++) begin
            n_cmp++;
            if (acc[i] != pa[i]) begin
                n_bad++;
                $display("FAIL stream_accept[%0d]: cyc=%0d want %0d", i, acc[i], pa[i]);
            end
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size() || base_q.size() != exp_base) begin
            n_bad++;
            $display("FAIL stream_count: writes=%0d pulses=%0d want %0d %0d",
                     obs_q.size(), base_q.size(), exp_q.size(), exp_base);
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i].addr != exp_q[i].addr || obs_q[i].data != exp_q[i].data) begin
                    n_bad++;
                    $display("FAIL stream_write[%0d]: addr=%0d data=%0d want %0d %0d",
                             i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
    endtask

    task automatic test_steel_and_range();
        int acc;
        clear_logs();
        send_hit(7, 5, 1, acc);
        send_hit(7, 6, 0, acc);
        send_hit(9, 12, 0, acc);
        n_cmp++;
        if (acc < 0) begin
            n_bad++;
            $display("FAIL y12_accept: acc=%0d want >=0", acc);
        end
        send_hit(9, 15, 1, acc);
        end_hit();
        repeat (10) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != (STEEL_EN ? 1 : 0)) begin
            n_bad++;
            $display("FAIL steel_count: writes=%0d want %0d", obs_q.size(), STEEL_EN ? 1 : 0);
        end else if (obs_q.size() == 1) begin
            n_cmp++;
            if (obs_q[0].addr != 87 || obs_q[0].data != 0) begin
                n_bad++;
                $display("FAIL steel_write: addr=%0d data=%0d want 87 0", obs_q[0].addr, obs_q[0].data);
            end
        end
    endtask

    task automatic test_load_flush();
        int b[3];
        int n = 0;
        int busy;
        for (int i = 0; i < 192 && n < 3; i++) if (mdl[i] == 1) begin b[n] = i; n++; end
        for (int i = 0; i < 256; i++) rom[i] = 3'($urandom_range(0, 7));
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            hit_valid = 1'b1;
            hit_x = 4'(b[k] % 16);
            hit_y = 4'(b[k] / 16);
            hit_power = 1'b0;
            if (k == 2) load_start = 1'b1;
        end
        @(negedge clk);
        hit_valid = 1'b0;
        load_start = 1'b0;
        busy = 0;
        while (load_busy && busy < 400) begin
            busy++;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        for (int i = 0; i < 192; i++) mdl[i] = int'(rom[i]);
        n_cmp++;
        if (obs_q.size() != 192) begin
            n_bad++;
            $display("FAIL flush_write_count: got %0d want 192 (found %0d bricks)", obs_q.size(), n);
        end else begin
            for (int i = 0; i < 192; i++) begin
                n_cmp++;
                if (obs_q[i].addr != i || obs_q[i].data != int'(rom[i])) begin
                    n_bad++;
                    $display("FAIL flush_load[%0d]: addr=%0d data=%0d want %0d %0d",
                             i, obs_q[i].addr, obs_q[i].data, i, rom[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({map_we, base_hit, load_busy, hit_ready, rom_addr, map_waddr, map_wdata, map_raddr}
            !== '0) begin
            n_bad++;
            $display("FAIL async_reset: we=%b bh=%b busy=%b rdy=%b rom=%0d wa=%0d wd=%0d ra=%0d want all 0",
                     map_we, base_hit, load_busy, hit_ready, rom_addr, map_waddr, map_wdata, map_raddr);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (load_busy !== 1'b0 || map_we !== 1'b0) begin
            n_bad++;
            $display("FAIL after_async_reset: busy=%b we=%b want 0 0", load_busy, map_we);
        end
    endtask

    initial begin
        test_reset();
        test_load_mod8();
        load_game_map();
        test_brick();
        test_base();
        test_back_to_back();
        test_steel_and_range();
        test_stream();
        test_load_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
